// File: rtl/jk_cmd_seq.sv
// Command FIFO that issues queued {J,K} pulses to a downstream JK flip-flop,
// tracks the expected Q in a shadow model and flags any returned-Q mismatch.
module jk_cmd_seq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd,
  output logic          cmd_ready,
  input  logic          en,
  output logic          J,
  output logic          K,
  input  logic          q_in,
  output logic          q_model,
  output logic          busy,
  output logic [CW-1:0] issued,
  output logic          err,
  input  logic          err_clr
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [1:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic            r_j, r_k, r_q_model, r_err;
  logic [CW-1:0]   r_issued;

  logic            w_full, w_empty, w_push, w_pop;
  logic [AW-1:0]   w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [CNTW-1:0] w_count_nxt;
  logic            w_j_nxt, w_k_nxt, w_q_model_nxt, w_err_nxt;
  logic [CW-1:0]   w_issued_nxt;

  // Occupancy is judged on the pre-edge count, so a same-cycle pop never
  // opens a slot and a fresh push never bypasses straight to issue.
  assign w_full  = (r_count == CNTW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = cmd_valid & ~w_full;
  assign w_pop   = en & ~w_empty;

  always_comb begin
    w_wr_ptr_nxt  = r_wr_ptr;
    w_rd_ptr_nxt  = r_rd_ptr;
    w_count_nxt   = r_count;
    w_j_nxt       = 1'b0;
    w_k_nxt       = 1'b0;
    w_issued_nxt  = r_issued;
    w_q_model_nxt = r_q_model;
    w_err_nxt     = (q_in != r_q_model) | (r_err & ~err_clr);

    if (w_push) w_wr_ptr_nxt = r_wr_ptr + AW'(1);
    if (w_pop) begin
      w_rd_ptr_nxt          = r_rd_ptr + AW'(1);
      {w_j_nxt, w_k_nxt}    = r_mem[r_rd_ptr];
      w_issued_nxt          = r_issued + CW'(1);
    end

    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNTW'(1);
      2'b01:   w_count_nxt = r_count - CNTW'(1);
      default: w_count_nxt = r_count;
    endcase

    // Shadow of the downstream FF, which samples J/K one edge after issue.
    case ({r_j, r_k})
      2'b10:   w_q_model_nxt = 1'b1;
      2'b01:   w_q_model_nxt = 1'b0;
      2'b11:   w_q_model_nxt = ~r_q_model;
      default: w_q_model_nxt = r_q_model;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_j       <= 1'b0;
      r_k       <= 1'b0;
      r_q_model <= 1'b0;
      r_issued  <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_push) r_mem[r_wr_ptr] <= cmd;
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_count   <= w_count_nxt;
      r_j       <= w_j_nxt;
      r_k       <= w_k_nxt;
      r_q_model <= w_q_model_nxt;
      r_issued  <= w_issued_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign cmd_ready = ~w_full;
  assign J         = r_j;
  assign K         = r_k;
  assign q_model   = r_q_model;
  assign issued    = r_issued;
  assign err       = r_err;
  assign busy      = ~w_empty | r_j | r_k;

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Directed and random stimulus for jk_cmd_seq against a queue-based model,
// with a behavioural downstream JK flip-flop closing the q_in loop.
module tb_jk_cmd_seq;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd = 2'b00;
  logic          cmd_ready;
  logic          en = 1'b0;
  logic          J, K;
  logic          q_in;
  logic          q_model;
  logic          busy;
  logic [CW-1:0] issued;
  logic          err;
  logic          err_clr = 1'b0;

  logic q_ff   = 1'b0;
  logic inject = 1'b0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [1:0]    m_q[$];
  logic          m_j = 1'b0, m_k = 1'b0, m_qm = 1'b0, m_err = 1'b0;
  logic [CW-1:0] m_issued = '0;

  always #5 clk = ~clk;

  jk_cmd_seq #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .en(en), .J(J), .K(K), .q_in(q_in), .q_model(q_model), .busy(busy),
    .issued(issued), .err(err), .err_clr(err_clr)
  );

  // Downstream JK flip-flop; its reset follows rst. inject flips the returned Q.
  always @(posedge clk) begin
    if (rst) q_ff <= 1'b0;
    else begin
      case ({J, K})
        2'b10:   q_ff <= 1'b1;
        2'b01:   q_ff <= 1'b0;
        2'b11:   q_ff <= ~q_ff;
        default: q_ff <= q_ff;
      endcase
    end
  end
  assign q_in = q_ff ^ inject;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance the model, then compare all outputs.
  task automatic cycle(input logic v, input logic [1:0] c, input logic e,
                       input logic clr = 1'b0, input logic r = 1'b0, input logic inj = 1'b0);
    logic acc;
    logic [1:0] head;
    cmd_valid = v; cmd = c; en = e; err_clr = clr; rst = r; inject = inj;
    if (r) begin
      m_q.delete();
      m_j = 1'b0; m_k = 1'b0; m_qm = 1'b0; m_issued = '0; m_err = 1'b0;
    end else begin
      acc   = v && (m_q.size() < DEPTH);
      m_err = ((q_ff ^ inj) != m_qm) || (m_err && !clr);
      if (m_j && !m_k) m_qm = 1'b1;
      else if (!m_j && m_k) m_qm = 1'b0;
      else if (m_j && m_k) m_qm = !m_qm;
      if (e && m_q.size() > 0) begin
        head = m_q.pop_front();
        m_j = head[1]; m_k = head[0];
        m_issued = m_issued + 1'b1;
      end else begin
        m_j = 1'b0; m_k = 1'b0;
      end
      if (acc) m_q.push_back(c);
    end
    @(posedge clk);
    #1;
    chk("cmd_ready", 32'(cmd_ready), 32'(m_q.size() < DEPTH));
    chk("J", 32'(J), 32'(m_j));
    chk("K", 32'(K), 32'(m_k));
    chk("q_model", 32'(q_model), 32'(m_qm));
    chk("busy", 32'(busy), 32'(m_q.size() > 0 || m_j || m_k));
    chk("issued", 32'(issued), 32'(m_issued));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 1'b1);
  endtask

  initial begin
    logic [1:0] rc;

    // Reset state
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_issued", 32'(issued), 32'd0);

    // Back-to-back set/clear/toggle/toggle
    cycle(1'b1, 2'b10, 1'b1);
    cycle(1'b1, 2'b01, 1'b1);
    cycle(1'b1, 2'b11, 1'b1);
    cycle(1'b1, 2'b11, 1'b1);
    idle(3);
    chk("seq_issued", 32'(issued), 32'd4);
    chk("seq_qmodel", 32'(q_model), 32'd0);
    chk("seq_err", 32'(err), 32'd0);

    // Fill with issuing frozen, then release while the 5th is still offered
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 2'b10, 1'b0);
    cycle(1'b1, 2'b01, 1'b0);
    cycle(1'b1, 2'b00, 1'b0);
    cycle(1'b1, 2'b11, 1'b0);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    cycle(1'b1, 2'b10, 1'b0);
    cycle(1'b1, 2'b10, 1'b1);
    cycle(1'b1, 2'b10, 1'b1);
    idle(6);
    chk("full_issued", 32'(issued), 32'd5);

    // Counter wrap on 256 toggles
    cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) cycle(1'b1, 2'b11, 1'b1);
    idle(2);
    chk("wrap_issued", 32'(issued), 32'd0);
    chk("wrap_qmodel", 32'(q_model), 32'd0);

    // Sticky error, clear, and set-wins on a simultaneous mismatch
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    chk("err_sticky", 32'(err), 32'd1);
    cycle(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("err_setwins", 32'(err), 32'd1);
    cycle(1'b0, 2'b00, 1'b1, 1'b1);
    chk("err_cleared", 32'(err), 32'd0);

    // Mid-stream reset discards queued and in-flight commands
    cycle(1'b1, 2'b10, 1'b0);
    cycle(1'b1, 2'b10, 1'b0);
    cycle(1'b1, 2'b01, 1'b0);
    cycle(1'b1, 2'b11, 1'b0);
    cycle(1'b0, 2'b00, 1'b1);
    chk("inflight_J", 32'(J), 32'd1);
    cycle(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_issued", 32'(issued), 32'd0);
    idle(4);
    chk("mrst_noissue", 32'(issued), 32'd0);

    // Hold command with q_model=1
    cycle(1'b1, 2'b10, 1'b1);
    idle(2);
    cycle(1'b1, 2'b00, 1'b1);
    cycle(1'b0, 2'b00, 1'b1);
    chk("hold_JK", 32'({J, K}), 32'd0);
    idle(2);
    chk("hold_qmodel", 32'(q_model), 32'd1);
    chk("hold_issued", 32'(issued), 32'd2);

    // Random traffic with occasional reset, error injection and clears
    for (int i = 0; i < 400; i++) begin
      rc = 2'($urandom_range(0, 3));
      cycle(1'($urandom_range(0, 3) != 0), rc, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 59) == 0),
            1'($urandom_range(0, 39) == 0));
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
